// File: rtl/vend_txn_fsm.sv
// Single-purchase vending transaction controller: select, price lookup, coin
// collection, dispense and change, driving item_memory Port A.
module vend_txn_fsm #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MEM_WAIT_MAX   = 15
) (
    input  logic                  clk_fsm,
    input  logic                  rstn,
    input  logic                  item_sel_valid,
    input  logic [ADDR_WIDTH-1:0] item_sel_addr,
    input  logic                  coin_valid,
    input  logic [15:0]           coin_value,
    input  logic                  cancel,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [15:0]           mem_item_cost,
    input  logic [7:0]            mem_item_available,
    input  logic                  mem_data_valid,
    output logic                  mem_update_en,
    output logic [ADDR_WIDTH-1:0] mem_update_addr,
    output logic                  dispense_valid,
    output logic [ADDR_WIDTH-1:0] dispense_addr,
    output logic                  change_valid,
    output logic [15:0]           change_amount,
    output logic                  coin_reject,
    output logic                  sold_out,
    output logic                  mem_error,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT     = 3'd2,
        ST_COLLECT  = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_CHANGE   = 3'd5
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [TO_W-1:0]       TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]       TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]       TO_ZERO   = {TO_W{1'b0}};
    localparam logic [WT_W-1:0]       WT_LAST   = WT_W'(MEM_WAIT_MAX - 1);
    localparam logic [WT_W-1:0]       WT_ONE    = WT_W'(1);
    localparam logic [WT_W-1:0]       WT_ZERO   = {WT_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   sel_addr_r;
    logic [15:0]             credit_r;
    logic [15:0]             cost_r;
    logic [TO_W-1:0]         to_cnt_r;
    logic [WT_W-1:0]         wait_cnt_r;
    logic [16:0]             credit_sum_s;
    logic [15:0]             credit_next_s;

    // Credit after this cycle's coin, saturating at 16'hFFFF.
    always_comb begin
        credit_sum_s  = {1'b0, credit_r} + {1'b0, coin_value};
        credit_next_s = credit_r;
        if (coin_valid) begin
            credit_next_s = credit_sum_s[16] ? 16'hFFFF : credit_sum_s[15:0];
        end else begin
            credit_next_s = credit_r;
        end
    end

    // Transaction state machine with all outputs registered.
    always_ff @(posedge clk_fsm or negedge rstn) begin
        if (!rstn) begin
            state_r         <= ST_IDLE;
            sel_addr_r      <= ADDR_ZERO;
            credit_r        <= 16'd0;
            cost_r          <= 16'd0;
            to_cnt_r        <= TO_ZERO;
            wait_cnt_r      <= WT_ZERO;
            mem_read_en     <= 1'b0;
            mem_read_addr   <= ADDR_ZERO;
            mem_update_en   <= 1'b0;
            mem_update_addr <= ADDR_ZERO;
            dispense_valid  <= 1'b0;
            dispense_addr   <= ADDR_ZERO;
            change_valid    <= 1'b0;
            change_amount   <= 16'd0;
            coin_reject     <= 1'b0;
            sold_out        <= 1'b0;
            mem_error       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            // Pulses default low; the address buses only carry a value with their strobe.
            mem_read_en     <= 1'b0;
            mem_read_addr   <= ADDR_ZERO;
            mem_update_en   <= 1'b0;
            mem_update_addr <= ADDR_ZERO;
            dispense_valid  <= 1'b0;
            dispense_addr   <= ADDR_ZERO;
            change_valid    <= 1'b0;
            change_amount   <= 16'd0;
            sold_out        <= 1'b0;
            mem_error       <= 1'b0;
            coin_reject     <= coin_valid && (state_r != ST_COLLECT);
            busy            <= 1'b1;

            case (state_r)
                ST_IDLE: begin
                    if (item_sel_valid) begin
                        sel_addr_r    <= item_sel_addr;
                        credit_r      <= 16'd0;
                        cost_r        <= 16'd0;
                        mem_read_en   <= 1'b1;
                        mem_read_addr <= item_sel_addr;
                        state_r       <= ST_REQ;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_REQ: begin
                    wait_cnt_r <= WT_ZERO;
                    state_r    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (mem_data_valid) begin
                        cost_r <= mem_item_cost;
                        if (mem_item_available == 8'd0) begin
                            sold_out <= 1'b1;
                            busy     <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else if (mem_item_cost == 16'd0) begin
                            mem_update_en   <= 1'b1;
                            mem_update_addr <= sel_addr_r;
                            dispense_valid  <= 1'b1;
                            dispense_addr   <= sel_addr_r;
                            state_r         <= ST_DISPENSE;
                        end else begin
                            to_cnt_r <= TO_LOAD;
                            state_r  <= ST_COLLECT;
                        end
                    end else if (wait_cnt_r == WT_LAST) begin
                        mem_error <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WT_ONE;
                    end
                end

                ST_COLLECT: begin
                    credit_r <= credit_next_s;
                    // Cancel beats a completing coin; the coin is still refunded.
                    if (cancel || (!coin_valid && (to_cnt_r == TO_ZERO))) begin
                        change_valid  <= (credit_next_s != 16'd0);
                        change_amount <= credit_next_s;
                        state_r       <= ST_CHANGE;
                    end else if (credit_next_s >= cost_r) begin
                        mem_update_en   <= 1'b1;
                        mem_update_addr <= sel_addr_r;
                        dispense_valid  <= 1'b1;
                        dispense_addr   <= sel_addr_r;
                        state_r         <= ST_DISPENSE;
                    end else if (coin_valid) begin
                        to_cnt_r <= TO_LOAD;
                    end else begin
                        to_cnt_r <= to_cnt_r - TO_ONE;
                    end
                end

                ST_DISPENSE: begin
                    change_valid  <= (credit_r != cost_r);
                    change_amount <= credit_r - cost_r;
                    state_r       <= ST_CHANGE;
                end

                ST_CHANGE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_txn_fsm.sv
// Directed bench for vend_txn_fsm: vector table plus hand sequences for
// timeout, mid-transaction reset and memory read timeout.
module tb_vend_txn_fsm;

    localparam int AW   = 10;
    localparam int TB_T = 40;
    localparam int TB_W = 6;

    logic          clk_fsm;
    logic          rstn;
    logic          item_sel_valid;
    logic [AW-1:0] item_sel_addr;
    logic          coin_valid;
    logic [15:0]   coin_value;
    logic          cancel;
    logic          mem_read_en;
    logic [AW-1:0] mem_read_addr;
    logic [15:0]   mem_item_cost;
    logic [7:0]    mem_item_available;
    logic          mem_data_valid;
    logic          mem_update_en;
    logic [AW-1:0] mem_update_addr;
    logic          dispense_valid;
    logic [AW-1:0] dispense_addr;
    logic          change_valid;
    logic [15:0]   change_amount;
    logic          coin_reject;
    logic          sold_out;
    logic          mem_error;
    logic          busy;

    logic          withhold;
    int            checks = 0;
    int            errors = 0;
    int            vidx   = 0;
    int            upd_cnt = 0;

    vend_txn_fsm #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TB_T),
        .MEM_WAIT_MAX  (TB_W)
    ) dut (
        .clk_fsm           (clk_fsm),
        .rstn              (rstn),
        .item_sel_valid    (item_sel_valid),
        .item_sel_addr     (item_sel_addr),
        .coin_valid        (coin_valid),
        .coin_value        (coin_value),
        .cancel            (cancel),
        .mem_read_en       (mem_read_en),
        .mem_read_addr     (mem_read_addr),
        .mem_item_cost     (mem_item_cost),
        .mem_item_available(mem_item_available),
        .mem_data_valid    (mem_data_valid),
        .mem_update_en     (mem_update_en),
        .mem_update_addr   (mem_update_addr),
        .dispense_valid    (dispense_valid),
        .dispense_addr     (dispense_addr),
        .change_valid      (change_valid),
        .change_amount     (change_amount),
        .coin_reject       (coin_reject),
        .sold_out          (sold_out),
        .mem_error         (mem_error),
        .busy              (busy)
    );

    initial clk_fsm = 1'b0;
    always #5 clk_fsm = ~clk_fsm;

    function automatic logic [15:0] cost_of(input logic [AW-1:0] a);
        case (a)
            10'd5:   return 16'd150;
            10'd7:   return 16'd10;
            10'd8:   return 16'd200;
            10'd9:   return 16'd100;
            10'd10:  return 16'd0;
            10'd11:  return 16'hFFFF;
            default: return 16'd1;
        endcase
    endfunction

    // Item memory stand-in: data one cycle after read_en is sampled.
    always @(posedge clk_fsm) begin
        mem_data_valid     <= mem_read_en && !withhold;
        mem_item_cost      <= cost_of(mem_read_addr);
        mem_item_available <= (mem_read_addr == 10'd7) ? 8'd0 : 8'd3;
    end

    always @(negedge clk_fsm) begin
        if (mem_update_en) upd_cnt <= upd_cnt + 1;
    end

    typedef struct {
        int            tid;
        logic          sel;
        logic [AW-1:0] addr;
        logic          coin;
        logic [15:0]   cv;
        logic          cn;
        logic          rd;
        logic          upd;
        logic          disp;
        logic [AW-1:0] oaddr;
        logic          chg;
        logic [15:0]   amt;
        logic          rej;
        logic          so;
        logic          err;
        logic          busy;
    } vec_t;

    function automatic vec_t mk(input int tid, input logic sel, input logic [AW-1:0] addr,
                                input logic coin, input logic [15:0] cv, input logic cn,
                                input logic rd, input logic upd, input logic disp,
                                input logic [AW-1:0] oaddr, input logic chg,
                                input logic [15:0] amt, input logic rej, input logic so,
                                input logic bsy);
        vec_t v;
        v.tid = tid; v.sel = sel; v.addr = addr; v.coin = coin; v.cv = cv; v.cn = cn;
        v.rd = rd; v.upd = upd; v.disp = disp; v.oaddr = oaddr; v.chg = chg; v.amt = amt;
        v.rej = rej; v.so = so; v.err = 1'b0; v.busy = bsy;
        return v;
    endfunction

    function automatic vec_t idle(input int tid, input logic bsy);
        return mk(tid, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, bsy);
    endfunction

    task automatic chk(input string what, input int tid, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d test %0d got %0h want %0h", what, vidx, tid, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk_fsm);
        item_sel_valid = v.sel;
        item_sel_addr  = v.addr;
        coin_valid     = v.coin;
        coin_value     = v.cv;
        cancel         = v.cn;
        @(posedge clk_fsm);
        #1;
        vidx++;
        chk("mem_read_en", v.tid, 32'(mem_read_en), 32'(v.rd));
        chk("mem_update_en", v.tid, 32'(mem_update_en), 32'(v.upd));
        chk("dispense_valid", v.tid, 32'(dispense_valid), 32'(v.disp));
        chk("change_valid", v.tid, 32'(change_valid), 32'(v.chg));
        chk("coin_reject", v.tid, 32'(coin_reject), 32'(v.rej));
        chk("sold_out", v.tid, 32'(sold_out), 32'(v.so));
        chk("mem_error", v.tid, 32'(mem_error), 32'(v.err));
        chk("busy", v.tid, 32'(busy), 32'(v.busy));
        if (v.rd)   chk("mem_read_addr", v.tid, 32'(mem_read_addr), 32'(v.oaddr));
        if (v.upd)  chk("mem_update_addr", v.tid, 32'(mem_update_addr), 32'(v.oaddr));
        if (v.disp) chk("dispense_addr", v.tid, 32'(dispense_addr), 32'(v.oaddr));
        if (v.chg)  chk("change_amount", v.tid, 32'(change_amount), 32'(v.amt));
    endtask

    task automatic chk_all_zero(input int tid);
        chk("rst mem_read_en", tid, 32'(mem_read_en), 32'd0);
        chk("rst mem_read_addr", tid, 32'(mem_read_addr), 32'd0);
        chk("rst mem_update_en", tid, 32'(mem_update_en), 32'd0);
        chk("rst mem_update_addr", tid, 32'(mem_update_addr), 32'd0);
        chk("rst dispense_valid", tid, 32'(dispense_valid), 32'd0);
        chk("rst dispense_addr", tid, 32'(dispense_addr), 32'd0);
        chk("rst change_valid", tid, 32'(change_valid), 32'd0);
        chk("rst change_amount", tid, 32'(change_amount), 32'd0);
        chk("rst coin_reject", tid, 32'(coin_reject), 32'd0);
        chk("rst sold_out", tid, 32'(sold_out), 32'd0);
        chk("rst mem_error", tid, 32'(mem_error), 32'd0);
        chk("rst busy", tid, 32'(busy), 32'd0);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rstn = 1'b0; withhold = 1'b0;
        item_sel_valid = 1'b0; item_sel_addr = '0;
        coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;

        // 1: pay 200 for a 150 item, change 50
        tbl.push_back(mk(1, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(1, 1'b1));
        tbl.push_back(idle(1, 1'b1));
        tbl.push_back(mk(1, 1'b0, 10'd0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b0, 10'd0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(1, 1'b0));
        // 2: sold out
        tbl.push_back(mk(2, 1'b1, 10'd7, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd7, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(2, 1'b1));
        tbl.push_back(mk(2, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(idle(2, 1'b0));
        // 3: cancel ignored in REQ/WAIT; cancel with coin refunds 75
        tbl.push_back(mk(3, 1'b1, 10'd8, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd8, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3, 1'b0, 10'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3, 1'b0, 10'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3, 1'b0, 10'd0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3, 1'b0, 10'd0, 1'b1, 16'd25, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 16'd75, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(3, 1'b0));
        // 3b: cancel beats a coin that would complete the sale
        tbl.push_back(mk(4, 1'b1, 10'd9, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd9, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(4, 1'b1));
        tbl.push_back(idle(4, 1'b1));
        tbl.push_back(mk(4, 1'b0, 10'd0, 1'b1, 16'd100, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(4, 1'b0));
        // 5: coin rejects in IDLE/WAIT, select ignored in COLLECT, exact pay
        tbl.push_back(mk(5, 1'b0, 10'd0, 1'b1, 16'd30, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(5, 1'b1, 10'd9, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd9, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(5, 1'b1));
        tbl.push_back(mk(5, 1'b0, 10'd0, 1'b1, 16'd40, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(5, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(5, 1'b0, 10'd0, 1'b1, 16'd60, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(5, 1'b0, 10'd0, 1'b1, 16'd40, 1'b0, 1'b0, 1'b1, 1'b1, 10'd9, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(5, 1'b1));
        tbl.push_back(idle(5, 1'b0));
        // 6: saturating credit against a 16'hFFFF price
        tbl.push_back(mk(6, 1'b1, 10'd11, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd11, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(6, 1'b1));
        tbl.push_back(idle(6, 1'b1));
        tbl.push_back(mk(6, 1'b0, 10'd0, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(6, 1'b0, 10'd0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1, 10'd11, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(6, 1'b1));
        tbl.push_back(idle(6, 1'b0));
        // 7: free item goes straight from WAIT to DISPENSE
        tbl.push_back(mk(7, 1'b1, 10'd10, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd10, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(7, 1'b1));
        tbl.push_back(mk(7, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd10, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(idle(7, 1'b1));
        tbl.push_back(idle(7, 1'b0));

        repeat (3) @(negedge clk_fsm);
        #1;
        chk_all_zero(0);
        @(negedge clk_fsm);
        rstn = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Timeout refund: exactly TB_T coinless cycles after the last coin
        apply(mk(8, 1'b1, 10'd9, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd9, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        apply(idle(8, 1'b1));
        apply(idle(8, 1'b1));
        apply(mk(8, 1'b0, 10'd0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        for (int i = 1; i < TB_T; i++) apply(idle(8, 1'b1));
        apply(mk(8, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b1));
        apply(idle(8, 1'b0));

        // Reset mid-COLLECT drops credit without a refund
        apply(mk(9, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        apply(idle(9, 1'b1));
        apply(idle(9, 1'b1));
        apply(mk(9, 1'b0, 10'd0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clk_fsm);
        item_sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        rstn = 1'b0;
        #1;
        chk_all_zero(9);
        @(negedge clk_fsm);
        rstn = 1'b1;
        apply(mk(9, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        apply(idle(9, 1'b1));
        apply(idle(9, 1'b1));
        apply(mk(9, 1'b0, 10'd0, 1'b1, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        apply(mk(9, 1'b0, 10'd0, 1'b1, 16'd50, 1'b0, 1'b0, 1'b1, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        apply(idle(9, 1'b1));
        apply(idle(9, 1'b0));

        // Memory never answers: mem_error after TB_W cycles in WAIT
        withhold = 1'b1;
        apply(mk(10, 1'b1, 10'd5, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1));
        for (int n = 1; n <= TB_W + 1; n++) begin
            v = idle(10, (n != TB_W + 1));
            v.err = (n == TB_W + 1);
            apply(v);
        end
        withhold = 1'b0;
        apply(idle(10, 1'b0));

        chk("update_count", 11, 32'(upd_cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_txn_fsm.md
Name: vend_txn_fsm

Overview:
- Transaction controller for one vending purchase: item selection, coin credit, stock check, dispense, change.
- Sits directly upstream of item_memory Port A on clk_fsm. Drives fsm_read_en/addr, consumes fsm_item_cost/available/data_valid, and issues the fsm_update_en stock/sales decrement.
- Front-panel keypad, coin acceptor, dispenser motor and change hopper interface to it via single-cycle pulses.

Parameters:
ADDR_WIDTH, 10, item address width; must match item_memory
TIMEOUT_CYCLES, 1000, clk_fsm cycles without a coin in COLLECT before auto-refund; must be >=2
MEM_WAIT_MAX, 15, cycles to wait for mem_data_valid before abort

Ports:
clk_fsm  in  1  system clock (100MHz)
rstn  in  1  asynchronous active-low reset
item_sel_valid  in  1  one-cycle item request pulse
item_sel_addr  in  ADDR_WIDTH  requested item index
coin_valid  in  1  one-cycle coin-inserted pulse
coin_value  in  16  coin value in cents
cancel  in  1  user cancel pulse
mem_read_en  out  1  to fsm_read_en
mem_read_addr  out  ADDR_WIDTH  to fsm_read_addr
mem_item_cost  in  16  from fsm_item_cost
mem_item_available  in  8  from fsm_item_available
mem_data_valid  in  1  from fsm_data_valid
mem_update_en  out  1  to fsm_update_en
mem_update_addr  out  ADDR_WIDTH  to fsm_update_addr
dispense_valid  out  1  one-cycle dispense pulse
dispense_addr  out  ADDR_WIDTH  item being dispensed
change_valid  out  1  one-cycle change/refund pulse
change_amount  out  16  value returned with change_valid
coin_reject  out  1  one-cycle pulse: coin arrived outside COLLECT, return it
sold_out  out  1  one-cycle pulse: selected item has zero stock
mem_error  out  1  one-cycle pulse: memory read timed out
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0 and state is IDLE. Credit, cost, address and counters clear to 0.
- Assertion of rstn mid-transaction drops everything immediately. No refund pulse is issued and credit is lost.
- States: IDLE, REQ, WAIT, COLLECT, DISPENSE, CHANGE.
- IDLE:
  - On item_sel_valid, latch item_sel_addr into sel_addr, clear credit, go to REQ.
  - Coins in IDLE pulse coin_reject the next cycle.
- REQ:
  - mem_read_en=1 and mem_read_addr=sel_addr for exactly one cycle, then WAIT.
  - item_memory returns mem_data_valid one cycle after it samples read_en.
- WAIT:
  - On mem_data_valid, latch cost.
  - If available==0, pulse sold_out and go to IDLE.
  - Else if cost==0, go to DISPENSE.
  - Else go to COLLECT.
  - If MEM_WAIT_MAX cycles pass without valid, pulse mem_error and go to IDLE.
- COLLECT:
  - Coin handling: on coin_valid, credit_next = min(credit + coin_value, 16'hFFFF), computed at 17 bits and saturated. Timeout counter reloads on every coin and on entry.
  - Dispense condition: if credit_next >= cost, go to DISPENSE.
  - cancel (including the same cycle as a coin, with the coin counted) or timeout expiry: load change_amount=credit_next, go to CHANGE with refund flag set, no dispense.
  - Priority when credit reaches cost in the same cycle as cancel: cancel wins.
- DISPENSE:
  - One cycle: mem_update_en=1, mem_update_addr=sel_addr, dispense_valid=1, dispense_addr=sel_addr.
  - change_amount <= credit - cost. Then go to CHANGE.
- CHANGE:
  - One cycle: change_valid=1 only if change_amount!=0; change_amount holds the value that cycle. Then go to IDLE.
- item_sel_valid when not IDLE is ignored (no queueing).
- Coins in REQ, WAIT, DISPENSE and CHANGE pulse coin_reject.
- cancel outside COLLECT is ignored. cancel in REQ/WAIT does not abort.
- Exactly one mem_update_en per successful sale. Never issued on refund, sold_out or mem_error.

Test Plan:
1. Select addr 5 (cost 150, avail 3) -> mem_read_en one cycle after select with addr 5. Coins 100 then 100 -> one dispense_valid with dispense_addr=5, mem_update_en with addr 5 same cycle, change_valid next cycle with change_amount=50, busy low after.
2. Select addr 7 (avail 0) -> sold_out pulse 2 cycles after mem_read_en. No update, no dispense, back to IDLE.
3. Select cost 200, coin 50, then coin 25 together with cancel -> change_valid with change_amount=75, no dispense_valid, no mem_update_en.
4. Select cost 100, coin 50, no further coins -> after TIMEOUT_CYCLES change_valid=50. Exact-pay run (coin 100) -> dispense with change_valid never asserted.
5. Coin while IDLE and coin during WAIT -> coin_reject pulse each, credit unaffected. item_sel_valid in COLLECT ignored (mem_read_en stays 0).
6. Credit 16'hFFF0 plus coin 100, cost 16'hFFFF -> credit saturates, dispense, change 0. rstn low in COLLECT -> all outputs 0 immediately, next select starts from credit 0. mem_data_valid withheld -> mem_error after MEM_WAIT_MAX.
